// File: rtl/mmio_uart_if.sv
// CPU-side bus, RAM read-data return and serial pins of the memory-mapped UART.
interface mmio_uart_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wren;
  logic [7:0]  rdata;
  logic [7:0]  ram_rdata;
  logic        ram_wren;
  logic        tx;
  logic        rx;

  modport master (output addr, wdata, wren, ram_rdata, rx,
                  input  rdata, ram_wren, tx);
  modport slave  (input  addr, wdata, wren, ram_rdata, rx,
                  output rdata, ram_wren, tx);
endinterface

// File: rtl/mmio_uart.sv
// UART mapped into a 16-byte I/O window on the CPU bus; splits RAM writes and
// muxes registered I/O read data onto the RAM read path with matching latency.
module mmio_uart #(
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int unsigned DIVISOR    = 217,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  mmio_uart_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned AW = PW + 1;
  localparam int unsigned CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          hit, sel_data, sel_status, wr_data, wr_status, rd_clr;
  logic          hit_q, data_q;
  logic [7:0]    io_rdata_q, status;
  logic [AW-1:0] wp, rp;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          tx_empty, tx_full, tx_idle, push_ok, pop;
  state_t        tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]    tx_bit, rx_bit;
  logic [7:0]    tx_sh, rx_sh, rx_byte;
  logic          tx_q, tx_tick, rx_tick, rx_s, rx_done_ok, rx_done_err;
  logic [1:0]    rx_sync;
  logic          rx_valid, rx_overrun, frame_err, tx_overflow;

  // Address decode; read-clear only on the first cycle DATA is addressed.
  assign hit        = bus.addr[15:4] == IO_BASE[15:4];
  assign sel_data   = hit && (bus.addr[3:0] == 4'h0);
  assign sel_status = hit && (bus.addr[3:0] == 4'h1);
  assign wr_data    = sel_data && bus.wren;
  assign wr_status  = sel_status && bus.wren;
  assign rd_clr     = sel_data && !bus.wren && !data_q;

  assign bus.ram_wren = bus.wren && !hit;
  assign bus.rdata    = hit_q ? io_rdata_q : bus.ram_rdata;
  assign bus.tx       = tx_q;

  assign status = {2'b00, tx_overflow, frame_err, rx_overrun, rx_valid, tx_idle, tx_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      data_q     <= 1'b0;
      io_rdata_q <= 8'h00;
    end else begin
      hit_q      <= hit;
      data_q     <= sel_data;
      io_rdata_q <= sel_data ? rx_byte : (sel_status ? status : 8'h00);
    end
  end

  // TX FIFO; a push into a full FIFO still lands if a pop frees a slot this cycle.
  assign tx_empty = wp == rp;
  assign tx_full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign push_ok  = wr_data && (!tx_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[PW-1:0]] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp + AW'(1);
    end
  end

  // TX shifter; the next frame chains straight out of STOP so frames stay 10 bits long.
  assign tx_tick = tx_cnt == BIT_LAST;
  assign pop     = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));
  assign tx_idle = tx_empty && (tx_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_q     <= 1'b1;
    end else if (pop) begin
      tx_state <= S_START;
      tx_cnt   <= '0;
      tx_sh    <= mem[rp[PW-1:0]];
      tx_q     <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: tx_cnt <= '0;
        S_START: begin
          if (tx_tick) begin
            tx_state <= S_DATA;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_q     <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx_q     <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_q   <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (tx_tick) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // RX receiver: synchronised input, start bit re-checked at mid-bit to reject glitches.
  assign rx_s        = rx_sync[1];
  assign rx_tick     = rx_cnt == BIT_LAST;
  assign rx_done_ok  = (rx_state == S_STOP) && rx_tick && rx_s;
  assign rx_done_err = (rx_state == S_STOP) && rx_tick && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_sync <= {rx_sync[0], bus.rx};
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) rx_state <= S_START;
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // RX buffer and sticky flags; a set always beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte     <= 8'h00;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rx_done_ok) rx_byte <= rx_sh;
      rx_valid    <= rx_done_ok || (rx_valid && !rd_clr);
      rx_overrun  <= (rx_done_ok && rx_valid && !rd_clr) ||
                     (rx_overrun && !(wr_status && bus.wdata[3]));
      frame_err   <= rx_done_err || (frame_err && !(wr_status && bus.wdata[4]));
      tx_overflow <= (wr_data && tx_full && !pop) ||
                     (tx_overflow && !(wr_status && bus.wdata[5]));
    end
  end
endmodule

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped UART and bus splitter sitting directly on the CPU's 8-bit memory bus, between the CPU and the synchronous RAM. It decodes a 16-byte I/O window, gates RAM writes for addresses inside it, and muxes registered I/O read data onto the CPU read path with the same one-cycle latency as RAM. It serialises CPU writes through a TX FIFO and captures received bytes into a one-byte RX buffer.

## Interface
- IO_BASE, 16'hFF00: base of the I/O window; decode is address[15:4] == IO_BASE[15:4].
- DIVISOR, 217: clocks per bit (25 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, ≥ 2.

- CLOCK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- I_ADDR  in  16  CPU address (the CPU's O_ADDR).
- I_DATA  in  8  CPU write data (the CPU's O_DATA).
- I_WREN  in  1  CPU write enable (the CPU's O_WREN).
- O_DATA  out  8  read data to the CPU's I_DATA.
- I_RAM_DATA  in  8  RAM read data (RAM registers its address).
- O_RAM_WREN  out  1  RAM write enable = I_WREN & ~hit.
- O_TX  out  1  serial out, idle high.
- I_RX  in  1  serial in, asynchronous.

## Operation
- hit = address in window. Registers by I_ADDR[3:0]:
  - 0x0 DATA: write pushes I_DATA to the TX FIFO. Read returns the RX byte.
  - 0x1 STATUS (read): bit0 tx_full, bit1 tx_idle (FIFO empty and shifter IDLE), bit2 rx_valid, bit3 rx_overrun, bit4 frame_err, bit5 tx_overflow, bits 7:6 = 0.
  - 0x1 STATUS (write): each 1 in bits 3..5 clears that sticky bit.
  - 0x2–0xF: read 0x00; writes ignored.
- Read path: hit_q and io_rdata_q are registered each cycle from I_ADDR. O_DATA = hit_q ? io_rdata_q : I_RAM_DATA (combinational mux).
- RX read-clear fires only on the first cycle the address equals DATA with I_WREN=0, i.e. the previous-cycle address was not DATA. A lingering address does not clear again.
- Software writes DATA with 8-bit STA [Rn]. A 16-bit STA to DATA also writes the high byte into STATUS.
- TX FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the rest are equal. Push when full is dropped and sets tx_overflow. Push and pop in the same cycle while full: the push is accepted.
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE. Each bit lasts DIVISOR cycles.
  - In IDLE with the FIFO non-empty: pop, load the shifter, drive O_TX=0 and enter START on the same edge.
  - From STOP, return to IDLE; back-to-back frames have no extra idle bit.
- RX path: 2-flop synchroniser on I_RX.
  - IDLE: on a low sample, go to START.
  - START: wait DIVISOR/2 cycles, re-sample. High → IDLE (glitch). Low → DATA.
  - DATA: sample 8 bits, each DIVISOR cycles apart, LSB first. Then STOP.
  - STOP: sample at mid-bit, then return to IDLE.
    - High: load the RX byte and set rx_valid. If rx_valid was already set, also set rx_overrun and overwrite the byte.
    - Low: set frame_err and discard the byte.
- Simultaneous events:
  - RX completion and read-clear in the same cycle: the new byte wins, rx_valid stays 1, no overrun.
  - Sticky set and write-clear in the same cycle: set wins.

## Timing
- Reset values: O_TX=1, hit_q=0 (so O_DATA = I_RAM_DATA), io_rdata_q=0, FIFO empty, all sticky bits 0, rx_valid=0, both FSMs IDLE.
- O_RAM_WREN has no reset dependency.
- Reset mid-frame: O_TX goes to 1 immediately, the FIFO empties and partial RX is discarded.
- Read latency: 1 cycle, identical to RAM. Address in cycle N gives data in cycle N+1.
- Register writes take effect at the edge ending the cycle with I_WREN=1.
- TX: a write to an empty FIFO with IDLE shifter at edge E0 drives O_TX low after E1. A frame is exactly 10·DIVISOR cycles. tx_idle returns to 1 after the STOP bit completes.
- RX: rx_valid rises at the mid-stop sample, about 2 + DIVISOR/2 + 9·DIVISOR cycles after the start edge on I_RX.

## Test plan
- Reset, DIVISOR=4: assert RESET_N=0 mid-TX frame → O_TX=1, STATUS reads 0x02 one cycle after the address is presented.
- STA [Rn] of 0x55 to 0xFF00 → O_RAM_WREN stays 0; O_TX shows 0,1,0,1,0,1,0,1,0,1, 4 cycles per bit, starting 1 cycle after the write edge.
- Push 10 bytes 0x00..0x09 while the FIFO is draining, FIFO_DEPTH=8 → exactly bytes dropped per the full rule are lost. tx_overflow=1. Writing 0x20 to STATUS clears it.
- Drive the 0xA3 frame on I_RX → STATUS bit2=1. Read 0xFF00 gives 0xA3 and rx_valid clears. Holding the address 3 more cycles keeps 0xA3 without a second clear.
- Two RX frames with no read between → rx_overrun=1 and DATA = the second byte. A frame with stop bit 0 → frame_err=1 and rx_valid unchanged.
- Read RAM address 0x1234 while RAM returns 0x7E → O_DATA=0x7E. Write to 0x1234 → O_RAM_WREN=1. Access to 0xFF05 → read 0x00 and O_RAM_WREN=0.
